// File: rtl/roberts_mdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : roberts_mdc_pkg
// Brief    : Shared types, default frame geometry and saturating adder.
// Revision : 1.0
// ============================================================================
package roberts_mdc_pkg;

    localparam int PIX_W_DEF      = 8;
    localparam int IMG_WIDTH_DEF  = 64;
    localparam int IMG_HEIGHT_DEF = 64;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    function automatic pixel_t sat_add(input pixel_t a, input pixel_t b);
        logic [PIX_W_DEF:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PIX_W_DEF] ? {PIX_W_DEF{1'b1}} : s[PIX_W_DEF-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/roberts_mdc_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : roberts_mdc_line_buffer
// Brief    : One-row register line buffer, shared address, read-before-write.
// Revision : 1.0
// ============================================================================
module roberts_mdc_line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/roberts_mdc_kernel.sv
`default_nettype none
// ============================================================================
// Module   : roberts_mdc_kernel
// Brief    : Roberts-cross gradient magnitude over a raster pixel stream.
// Revision : 1.0
// ============================================================================
module roberts_mdc_kernel
    import roberts_mdc_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        frame_done_o
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] left_q, left_d, upleft_q, upleft_d;
    logic [PIX_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic             w_hs, w_load, w_last;
    logic [PIX_W-1:0] w_pix, w_up, w_abs1, w_abs2, w_sat, w_g;
    logic signed [PIX_W:0] w_d1, w_d2;
    logic             w_unused_bits;

    assign w_unused_bits = ^in_data_i[31:PIX_W];
    assign w_pix  = in_data_i[PIX_W-1:0];
    assign in_ready_o = !rst_i && (!valid_q || out_ready_i);
    assign w_hs   = in_valid_i && in_ready_o;
    assign w_load = w_hs && !clear_i;
    assign w_last = (col_q == COL_LAST) && (row_q == ROW_LAST);

    roberts_mdc_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_line_buffer (
        .clk_i   (clk_i),
        .we_i    (w_load),
        .addr_i  (col_q),
        .wdata_i (w_pix),
        .rdata_o (w_up)
    );

    // Differences are one bit wider than a pixel so the sign survives.
    assign w_d1   = $signed({1'b0, upleft_q}) - $signed({1'b0, w_pix});
    assign w_d2   = $signed({1'b0, w_up}) - $signed({1'b0, left_q});
    assign w_abs1 = w_d1[PIX_W] ? PIX_W'(-w_d1) : w_d1[PIX_W-1:0];
    assign w_abs2 = w_d2[PIX_W] ? PIX_W'(-w_d2) : w_d2[PIX_W-1:0];

    if (PIX_W == PIX_W_DEF) begin : g_pkg_sat
        assign w_sat = sat_add(w_abs1, w_abs2);
    end else begin : g_gen_sat
        logic [PIX_W:0] w_sum;
        assign w_sum = {1'b0, w_abs1} + {1'b0, w_abs2};
        assign w_sat = w_sum[PIX_W] ? {PIX_W{1'b1}} : w_sum[PIX_W-1:0];
    end

    assign w_g = ((row_q == '0) || (col_q == '0)) ? '0 : w_sat;

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        left_d   = left_q;
        upleft_d = upleft_q;
        out_d    = out_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        if (clear_i) begin
            col_d   = '0;
            row_d   = '0;
            out_d   = '0;
            valid_d = 1'b0;
        end else if (w_hs) begin
            out_d    = w_g;
            valid_d  = 1'b1;
            done_d   = w_last;
            left_d   = w_pix;
            upleft_d = w_up;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q    <= '0;
            row_q    <= '0;
            left_q   <= '0;
            upleft_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            left_q   <= left_d;
            upleft_q <= upleft_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign out_data_o   = {{(32-PIX_W){1'b0}}, out_q};
    assign out_valid_o  = valid_q;
    assign frame_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_roberts_mdc_kernel.sv
`default_nettype none
// ============================================================================
// Module   : tb_roberts_mdc_kernel
// Brief    : Scoreboard bench for roberts_mdc_kernel on a 4x3 frame.
// Revision : 1.0
// ============================================================================
module tb_roberts_mdc_kernel;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic [31:0] in_data_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic        frame_done_o;

    roberts_mdc_kernel #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIX_W      (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int g;
        bit last;
    } exp_t;

    exp_t q[$];
    int   img[H][W];
    int   mr = 0, mc = 0;
    int   n_vec = 0, n_err = 0, n_chk = 0;
    bit   rdy_rand = 1'b0;
    int   stall_cnt = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: Roberts cross straight from the raster image, saturated.
    function automatic void model_push(int p);
        exp_t e;
        int   s;
        if (mr == 0 || mc == 0) s = 0;
        else s = iabs(img[mr-1][mc-1] - p) + iabs(img[mr-1][mc] - img[mr][mc-1]);
        e.g    = (s > 255) ? 255 : s;
        e.last = (mr == H-1) && (mc == W-1);
        img[mr][mc] = p;
        q.push_back(e);
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end
    endfunction

    task automatic send(input int p);
        bit done = 1'b0;
        int guard = 0;
        in_valid_i = 1'b1;
        in_data_i  = {24'($urandom), 8'(p)};
        while (!done) begin
            @(negedge clk);
            if (in_ready_o) begin
                model_push(p);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 200) begin
                chk("send_timeout", 0, 1);
                done = 1'b1;
            end
        end
        in_valid_i = 1'b0;
        n_vec++;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (stall_cnt > 0) begin
            out_ready_i = 1'b0;
            stall_cnt--;
        end else if (rdy_rand) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready_i = 1'b1;
        end
    end

    bit          prev_valid = 1'b0;
    bit          prev_xfer  = 1'b0;
    logic [31:0] held;

    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid_o) begin
                if (!prev_valid || prev_xfer) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", int'(out_data_o), e.g);
                        chk("frame_done", int'(frame_done_o), int'(e.last));
                    end
                    held = out_data_o;
                end else begin
                    chk("stall_data_stable", int'(out_data_o), int'(held));
                    chk("stall_frame_done_low", int'(frame_done_o), 0);
                end
                if (!out_ready_i) chk("stall_in_ready_low", int'(in_ready_o), 0);
            end else begin
                chk("idle_frame_done_low", int'(frame_done_o), 0);
            end
            prev_valid = out_valid_o;
            prev_xfer  = out_valid_o && out_ready_i;
        end
    end

    initial begin
        int guard;
        // Reset with a pending input word: nothing may be accepted.
        in_valid_i = 1'b1;
        in_data_i  = 32'h0000_0077;
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", int'(in_ready_o), 0);
            chk("rst_out_valid", int'(out_valid_o), 0);
            chk("rst_out_data", int'(out_data_o), 0);
            chk("rst_frame_done", int'(frame_done_o), 0);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready_o), 1);
        chk("post_rst_out_valid", int'(out_valid_o), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < W*H; i++) send(100);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) send(10 * (4*r + c));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) send((c % 2 == 1) ? 255 : 0);
        idle(3);

        // Ramp with a 5-cycle downstream stall in the middle of row 1.
        for (int i = 0; i < W*H; i++) begin
            send(10 * i);
            if (i == 5) stall_cnt = 5;
        end
        idle(3);

        // Five pixels, then a clear cycle carrying a word that must be dropped.
        for (int i = 0; i < 5; i++) send($urandom_range(0, 255));
        clear_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 32'h0000_00AB;
        @(posedge clk);
        #1;
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        mr = 0;
        mc = 0;
        for (int i = 0; i < W*H; i++) send(10 * i);

        // Random frames with input gaps and random downstream readiness.
        rdy_rand = 1'b1;
        for (int i = 0; i < 3*W*H; i++) begin
            send($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rdy_rand = 1'b0;

        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
